pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 37 +++
 rtl/pipe_ctrl_hazard_detect.sv | 34 +++
 rtl/pipe_ctrl.sv | 146 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared core definitions for the pipeline controller:
//   GPR_ADDR_W  - width of a general-purpose register address (32 GPRs)
//   CNT_W_DEF   - default width of the performance counters
//   ST_*        - mul/div FSM state encoding
//   ctrl_t      - bundle of the stall/flush controls driven to the pipeline
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

  localparam int GPR_ADDR_W = 5;
  localparam int CNT_W_DEF  = 32;

  // mul/div sequencing states
  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_MD_WAIT = 2'd1;
  localparam logic [1:0] ST_MD_DONE = 2'd2;

  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic id_exe_stall;
    logic exe_mem_stall;
    logic if_id_flush;
    logic id_exe_flush;
    logic exe_mem_flush;
    logic mem_wb_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE  = '0;
  // while in reset every stage register is loaded with a bubble
  localparam ctrl_t CTRL_RESET = '{pc_stall: 1'b0, if_id_stall: 1'b0,
                                   id_exe_stall: 1'b0, exe_mem_stall: 1'b0,
                                   if_id_flush: 1'b1, id_exe_flush: 1'b1,
                                   exe_mem_flush: 1'b1, mem_wb_flush: 1'b1};

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
// Flags a load-use hazard: the instruction in EXE is a load writing a non-zero
// register that the instruction in ID actually reads.
// Ports:
//   rs1_addr, rs2_addr  in  source registers of the ID instruction
//   rs1_re, rs2_re      in  source register is really read
//   rd_addr             in  destination of the EXE instruction
//   rd_we, mem_re       in  EXE writes rd / EXE is a load
//   load_use            out hazard present
// -----------------------------------------------------------------------------
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [GPR_ADDR_W-1:0] rs1_addr,
  input  logic [GPR_ADDR_W-1:0] rs2_addr,
  input  logic                  rs1_re,
  input  logic                  rs2_re,
  input  logic [GPR_ADDR_W-1:0] rd_addr,
  input  logic                  rd_we,
  input  logic                  mem_re,
  output logic                  load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = rs1_re && (rs1_addr == rd_addr);
  assign rs2_hit = rs2_re && (rs2_addr == rd_addr);

  // x0 is hard-wired to zero, so a load targeting it never creates a hazard
  assign load_use = mem_re && rd_we && (rd_addr != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
// Central stall/flush controller of the 5-stage pipeline, with performance
// counters. Hold sources, highest priority first: MEM busy, mul/div in
// flight, taken branch flush, load-use bubble.
// Ports:
//   clk_i, rst_i                      clock, async active-high reset
//   id_rs1/rs2_addr_i, id_rs1/rs2_re_i ID source operands
//   exe_rd_addr_i, exe_rd_we_i,
//   exe_mem_re_i                      EXE destination / load indication
//   exe_br_taken_i                    branch resolved taken in EXE
//   exe_md_start_i, exe_md_done_i     mul/div launch and completion pulse
//   mem_busy_i                        data memory not ready
//   *_stall_o                         hold the stage register
//   *_flush_o                         load a bubble into the stage register
//   stall_cnt_o, flush_cnt_o          saturating performance counters
// -----------------------------------------------------------------------------
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [GPR_ADDR_W-1:0] id_rs1_addr_i,
  input  logic [GPR_ADDR_W-1:0] id_rs2_addr_i,
  input  logic                  id_rs1_re_i,
  input  logic                  id_rs2_re_i,
  input  logic [GPR_ADDR_W-1:0] exe_rd_addr_i,
  input  logic                  exe_rd_we_i,
  input  logic                  exe_mem_re_i,
  input  logic                  exe_br_taken_i,
  input  logic                  exe_md_start_i,
  input  logic                  exe_md_done_i,
  input  logic                  mem_busy_i,
  output logic                  pc_stall_o,
  output logic                  if_id_stall_o,
  output logic                  id_exe_stall_o,
  output logic                  exe_mem_stall_o,
  output logic                  if_id_flush_o,
  output logic                  id_exe_flush_o,
  output logic                  exe_mem_flush_o,
  output logic                  mem_wb_flush_o,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o
);

  logic [1:0] state;
  logic [1:0] state_next;
  logic       load_use;
  logic       md_hold;
  logic       br_flush;
  ctrl_t      ctrl;

  hazard_detect u_hazard_detect (
    .rs1_addr (id_rs1_addr_i),
    .rs2_addr (id_rs2_addr_i),
    .rs1_re   (id_rs1_re_i),
    .rs2_re   (id_rs2_re_i),
    .rd_addr  (exe_rd_addr_i),
    .rd_we    (exe_rd_we_i),
    .mem_re   (exe_mem_re_i),
    .load_use (load_use)
  );

  // A start that completes in the same cycle needs no hold; a done pulse in
  // MD_WAIT releases the pipeline in that very cycle.
  assign md_hold = ((state == ST_RUN) && exe_md_start_i && !exe_md_done_i) ||
                   ((state == ST_MD_WAIT) && !exe_md_done_i);

  assign br_flush = !rst_i && !mem_busy_i && !md_hold && exe_br_taken_i;

  // A start seen while MEM is busy is ignored: EXE is held and re-presents it.
  // A done arriving under MEM busy is remembered in MD_DONE until MEM frees.
  always_comb begin
    state_next = state;
    case (state)
      ST_RUN:
        if (!mem_busy_i && exe_md_start_i && !exe_md_done_i)
          state_next = ST_MD_WAIT;
      ST_MD_WAIT:
        if (exe_md_done_i)
          state_next = mem_busy_i ? ST_MD_DONE : ST_RUN;
      ST_MD_DONE:
        if (!mem_busy_i)
          state_next = ST_RUN;
      default:
        state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_RUN;
    else       state <= state_next;
  end

  // Priority resolution; a lower source is only seen when all higher ones idle.
  always_comb begin
    ctrl = CTRL_IDLE;
    if (rst_i) begin
      ctrl = CTRL_RESET;
    end else if (mem_busy_i) begin
      ctrl.pc_stall      = 1'b1;
      ctrl.if_id_stall   = 1'b1;
      ctrl.id_exe_stall  = 1'b1;
      ctrl.exe_mem_stall = 1'b1;
      ctrl.mem_wb_flush  = 1'b1;
    end else if (md_hold) begin
      ctrl.pc_stall      = 1'b1;
      ctrl.if_id_stall   = 1'b1;
      ctrl.id_exe_stall  = 1'b1;
      ctrl.exe_mem_flush = 1'b1;
    end else if (exe_br_taken_i) begin
      ctrl.if_id_flush   = 1'b1;
      ctrl.id_exe_flush  = 1'b1;
    end else if (load_use) begin
      // the bubble moves the load on to MEM, so this lasts one cycle per load
      ctrl.pc_stall      = 1'b1;
      ctrl.if_id_stall   = 1'b1;
      ctrl.id_exe_flush  = 1'b1;
    end
  end

  assign pc_stall_o      = ctrl.pc_stall;
  assign if_id_stall_o   = ctrl.if_id_stall;
  assign id_exe_stall_o  = ctrl.id_exe_stall;
  assign exe_mem_stall_o = ctrl.exe_mem_stall;
  assign if_id_flush_o   = ctrl.if_id_flush;
  assign id_exe_flush_o  = ctrl.id_exe_flush;
  assign exe_mem_flush_o = ctrl.exe_mem_flush;
  assign mem_wb_flush_o  = ctrl.mem_wb_flush;

  // Saturating performance counters
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (pc_stall_o && (stall_cnt_o != '1))
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      if (br_flush && (flush_cnt_o != '1))
        flush_cnt_o <= flush_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl
// Directed bench for pipe_ctrl. Inputs change 1ns after a rising edge, the
// combinational controls are sampled 3ns later, and counters/state are sampled
// 1ns after the following edge. Counters are narrowed to 4 bits so saturation
// can be reached quickly.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

  localparam int CNT_W = 4;

  // control vector layout {pc,if_id,id_exe,exe_mem stall, if_id,id_exe,exe_mem,mem_wb flush}
  localparam logic [7:0] C_NONE = 8'h00;
  localparam logic [7:0] C_MEM  = 8'hF1;
  localparam logic [7:0] C_MD   = 8'hE2;
  localparam logic [7:0] C_BR   = 8'h0C;
  localparam logic [7:0] C_LU   = 8'hC4;
  localparam logic [7:0] C_RST  = 8'h0F;

  logic clk_i = 1'b0;
  logic rst_i;
  logic [4:0] id_rs1_addr_i, id_rs2_addr_i, exe_rd_addr_i;
  logic id_rs1_re_i, id_rs2_re_i, exe_rd_we_i, exe_mem_re_i;
  logic exe_br_taken_i, exe_md_start_i, exe_md_done_i, mem_busy_i;
  logic pc_stall_o, if_id_stall_o, id_exe_stall_o, exe_mem_stall_o;
  logic if_id_flush_o, id_exe_flush_o, exe_mem_flush_o, mem_wb_flush_o;
  logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;
  logic [7:0] ctrl;

  int numCompared   = 0;
  int numMismatched = 0;
  int expStall      = 0;
  int expFlush      = 0;

  always #5 clk_i = ~clk_i;

  pipe_ctrl #(.CNT_W(CNT_W)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .id_rs1_addr_i   (id_rs1_addr_i),
    .id_rs2_addr_i   (id_rs2_addr_i),
    .id_rs1_re_i     (id_rs1_re_i),
    .id_rs2_re_i     (id_rs2_re_i),
    .exe_rd_addr_i   (exe_rd_addr_i),
    .exe_rd_we_i     (exe_rd_we_i),
    .exe_mem_re_i    (exe_mem_re_i),
    .exe_br_taken_i  (exe_br_taken_i),
    .exe_md_start_i  (exe_md_start_i),
    .exe_md_done_i   (exe_md_done_i),
    .mem_busy_i      (mem_busy_i),
    .pc_stall_o      (pc_stall_o),
    .if_id_stall_o   (if_id_stall_o),
    .id_exe_stall_o  (id_exe_stall_o),
    .exe_mem_stall_o (exe_mem_stall_o),
    .if_id_flush_o   (if_id_flush_o),
    .id_exe_flush_o  (id_exe_flush_o),
    .exe_mem_flush_o (exe_mem_flush_o),
    .mem_wb_flush_o  (mem_wb_flush_o),
    .stall_cnt_o     (stall_cnt_o),
    .flush_cnt_o     (flush_cnt_o)
  );

  assign ctrl = {pc_stall_o, if_id_stall_o, id_exe_stall_o, exe_mem_stall_o,
                 if_id_flush_o, id_exe_flush_o, exe_mem_flush_o, mem_wb_flush_o};

  // Drives one input vector: ID operands, EXE load info, then event inputs
  task applyStimulus(input logic [4:0] rs1, input logic rs1_re,
                     input logic [4:0] rs2, input logic rs2_re,
                     input logic [4:0] rd, input logic rd_we, input logic mem_re,
                     input logic br, input logic md_start, input logic md_done,
                     input logic busy);
    id_rs1_addr_i  = rs1;
    id_rs1_re_i    = rs1_re;
    id_rs2_addr_i  = rs2;
    id_rs2_re_i    = rs2_re;
    exe_rd_addr_i  = rd;
    exe_rd_we_i    = rd_we;
    exe_mem_re_i   = mem_re;
    exe_br_taken_i = br;
    exe_md_start_i = md_start;
    exe_md_done_i  = md_done;
    mem_busy_i     = busy;
  endtask

  task checkOutput(input string tag, input logic [31:0] observed,
                   input logic [31:0] expected);
    numCompared++;
    if (observed !== expected) begin
      numMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task idle();
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task nextEdge();
    @(posedge clk_i);
    #1;
  endtask

  // applies a plain mul/div/busy vector, checks controls, then advances a cycle
  task mdCycle(input string tag, input logic start, input logic done,
               input logic busy, input logic [7:0] expCtrl);
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, start, done, busy);
    #3;
    checkOutput(tag, 32'(ctrl), 32'(expCtrl));
    if (expCtrl[7]) expStall++;
    nextEdge();
  endtask

  initial begin
    rst_i = 1'b1;
    idle();
    #3;
    checkOutput("reset_ctrl", 32'(ctrl), 32'(C_RST));
    checkOutput("reset_state", 32'(dut.state), 32'(0));
    checkOutput("reset_stall_cnt", 32'(stall_cnt_o), 32'(0));
    checkOutput("reset_flush_cnt", 32'(flush_cnt_o), 32'(0));
    nextEdge();
    nextEdge();
    rst_i = 1'b0;
    #3;
    checkOutput("idle_ctrl", 32'(ctrl), 32'(C_NONE));
    nextEdge();

    // load x5 in EXE, ID reads rs2 = x5
    applyStimulus(5'd3, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #3;
    checkOutput("lu_rs2", 32'(ctrl), 32'(C_LU));
    nextEdge();
    expStall = 1;
    checkOutput("lu_stall_cnt", 32'(stall_cnt_o), 32'(expStall));
    // same with rd = x0
    applyStimulus(5'd3, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #3;
    checkOutput("lu_x0", 32'(ctrl), 32'(C_NONE));
    // rs1 matches but is not read
    applyStimulus(5'd7, 1'b0, 5'd2, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #3;
    checkOutput("lu_rs1_not_read", 32'(ctrl), 32'(C_NONE));
    // rs1 match through rs1 read enable
    applyStimulus(5'd7, 1'b1, 5'd2, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("lu_rs1", 32'(ctrl), 32'(C_LU));
    // matching non-load writer is no hazard
    applyStimulus(5'd7, 1'b1, 5'd2, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("lu_not_load", 32'(ctrl), 32'(C_NONE));
    nextEdge();
    checkOutput("no_lu_stall_cnt", 32'(stall_cnt_o), 32'(expStall));

    // branch taken with a load-use present: flush wins
    applyStimulus(5'd3, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #3;
    checkOutput("br_over_lu", 32'(ctrl), 32'(C_BR));
    nextEdge();
    expFlush = 1;
    checkOutput("br_flush_cnt", 32'(flush_cnt_o), 32'(expFlush));
    checkOutput("br_stall_cnt", 32'(stall_cnt_o), 32'(expStall));

    // start with done in the same cycle: no hold, no transition
    mdCycle("md_start_done", 1'b1, 1'b1, 1'b0, C_NONE);
    checkOutput("md_start_done_state", 32'(dut.state), 32'(0));

    // start at t0, done at t4
    mdCycle("md_t0", 1'b1, 1'b0, 1'b0, C_MD);
    checkOutput("md_wait_state", 32'(dut.state), 32'(1));
    mdCycle("md_t1", 1'b0, 1'b0, 1'b0, C_MD);
    mdCycle("md_t2", 1'b0, 1'b0, 1'b0, C_MD);
    mdCycle("md_t3", 1'b0, 1'b0, 1'b0, C_MD);
    mdCycle("md_t4_done", 1'b0, 1'b1, 1'b0, C_NONE);
    checkOutput("md_t5_state", 32'(dut.state), 32'(0));
    checkOutput("md_stall_cnt", 32'(stall_cnt_o), 32'(5));

    // done under MEM busy parks in MD_DONE
    mdCycle("mdd_t0", 1'b1, 1'b0, 1'b0, C_MD);
    mdCycle("mdd_t1", 1'b0, 1'b0, 1'b0, C_MD);
    mdCycle("mdd_t2", 1'b0, 1'b1, 1'b1, C_MEM);
    checkOutput("mdd_t3_state", 32'(dut.state), 32'(2));
    mdCycle("mdd_t3", 1'b0, 1'b0, 1'b1, C_MEM);
    checkOutput("mdd_t4_state", 32'(dut.state), 32'(2));
    mdCycle("mdd_t4", 1'b0, 1'b0, 1'b0, C_NONE);
    checkOutput("mdd_t5_state", 32'(dut.state), 32'(0));
    checkOutput("mdd_stall_cnt", 32'(stall_cnt_o), 32'(9));

    // MEM busy with a branch: hold only, no flush count
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    #3;
    checkOutput("busy_br", 32'(ctrl), 32'(C_MEM));
    nextEdge();
    expStall++;
    checkOutput("busy_br_flush_cnt", 32'(flush_cnt_o), 32'(expFlush));
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    #3;
    checkOutput("br_after_busy", 32'(ctrl), 32'(C_BR));
    nextEdge();
    expFlush++;
    checkOutput("br_after_busy_cnt", 32'(flush_cnt_o), 32'(expFlush));

    // start under MEM busy is ignored
    mdCycle("start_busy", 1'b1, 1'b0, 1'b1, C_MEM);
    checkOutput("start_busy_state", 32'(dut.state), 32'(0));
    checkOutput("start_busy_stall_cnt", 32'(stall_cnt_o), 32'(11));
    mdCycle("start_again", 1'b1, 1'b0, 1'b0, C_MD);
    checkOutput("start_again_state", 32'(dut.state), 32'(1));

    // reset between edges while in MD_WAIT
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    rst_i = 1'b1;
    #1;
    checkOutput("midrst_ctrl", 32'(ctrl), 32'(C_RST));
    checkOutput("midrst_state", 32'(dut.state), 32'(0));
    checkOutput("midrst_stall_cnt", 32'(stall_cnt_o), 32'(0));
    checkOutput("midrst_flush_cnt", 32'(flush_cnt_o), 32'(0));
    nextEdge();
    rst_i = 1'b0;

    // saturation: 20 MEM-busy cycles on a 4-bit counter
    for (int i = 0; i < 20; i++)
      mdCycle("sat_busy", 1'b0, 1'b0, 1'b1, C_MEM);
    checkOutput("stall_cnt_sat", 32'(stall_cnt_o), 32'(15));
    checkOutput("sat_state", 32'(dut.state), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
